// File: rtl/mul16u_arb_ctrl.sv
// Round-robin front end that shares one external combinational 16x16 unsigned
// multiplier among N_REQ requesters. Two register stages surround the
// multiplier: S1 holds the selected operands (driving mul_a/mul_b) and S2
// captures the returned product for the response port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A requester keeps valid and its operands stable until it sees its
// ready bit. rsp_valid, rsp_o and rsp_id hold still until rsp_ready.
module mul16u_arb_ctrl #(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_o,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_o,
    output logic [2:0]           rsp_id,
    output logic [15:0]          ops_done
);

    localparam int IW = $clog2(N_REQ);

    logic          s1_valid;
    logic [2:0]    s1_id;
    logic [IW-1:0] ptr;

    logic          adv;
    logic          ld1;
    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   cand_sum;
    logic [IW-1:0] cand;
    logic [15:0]   gnt_a;
    logic [15:0]   gnt_b;

    // S2 can take a new value when empty or being drained; S1 when empty or
    // when its content moves on into S2 this cycle.
    assign adv = !rsp_valid || rsp_ready;
    assign ld1 = !s1_valid || adv;

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(N_REQ)) begin
                cand_sum = cand_sum - (IW+1)'(N_REQ);
            end
            cand = cand_sum[IW-1:0];
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (k == int'(gnt_idx)) begin
                gnt_a = req_a[16*k +: 16];
                gnt_b = req_b[16*k +: 16];
            end
        end
    end

    // One-hot accept, only when S1 can load and never during reset.
    always_comb begin
        req_ready = '0;
        if (ld1 && gnt_any && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // S1 stage and arbitration pointer; operands hold their last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            ptr      <= '0;
        end else if (ld1) begin
            s1_valid <= gnt_any;
            if (gnt_any) begin
                mul_a <= gnt_a;
                mul_b <= gnt_b;
                s1_id <= 3'(gnt_idx);
                ptr   <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // S2 stage captures the multiplier output unmodified.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_o     <= '0;
            rsp_id    <= '0;
        end else if (adv) begin
            rsp_valid <= s1_valid;
            rsp_o     <= mul_o;
            rsp_id    <= s1_id;
        end
    end

    // Completed-response counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done <= '0;
        end else if (rsp_valid && rsp_ready && (ops_done != 16'hFFFF)) begin
            ops_done <= ops_done + 16'd1;
        end
    end

endmodule
